// File: rtl/fpu_align_shifter.sv
// rtl/fpu_align_shifter.sv - serial mantissa alignment shifter with guard/round/sticky collection
// Optional sticky accumulation on shift and saturate paths: define FPU_ALIGN_STICKY_EN.
module fpu_align_shifter #(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [EXP_W-1:0]  exp_diff,
   input  logic              diff_sign,
   input  logic              diff_ovf,
   input  logic [EXP_W-1:0]  exp_a,
   input  logic [EXP_W-1:0]  exp_b,
   input  logic [MANT_W-1:0] mant_a,
   input  logic [MANT_W-1:0] mant_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MANT_W-1:0] big_mant,
   output logic [MANT_W+2:0] small_ext,
   output logic [EXP_W-1:0]  common_exp,
   output logic              swapped
);
   localparam int EXT_W = MANT_W + 3;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t              state_q, state_d;
   logic [EXP_W-1:0]    count_q, count_d;
   logic [MANT_W-1:0]   big_mant_q, big_mant_d;
   logic [EXT_W-1:0]    small_ext_q, small_ext_d;
   logic [EXP_W-1:0]    common_exp_q, common_exp_d;
   logic                swapped_q, swapped_d;

   logic [MANT_W-1:0]   other_mant;
   logic                saturate;
   logic [EXT_W-1:0]    shifted;
   logic [EXT_W-1:0]    sat_ext;

   assign other_mant = diff_sign ? mant_a : mant_b;
   // Differences of EXT_W or more push every mantissa bit below S.
   assign saturate   = diff_ovf || (32'(exp_diff) >= 32'(EXT_W));

`ifdef FPU_ALIGN_STICKY_EN
   assign shifted = {1'b0, small_ext_q[EXT_W-1:2], small_ext_q[1] | small_ext_q[0]};
   assign sat_ext = {{(EXT_W-1){1'b0}}, |other_mant};
`else
   assign shifted = {1'b0, small_ext_q[EXT_W-1:2], 1'b0};
   assign sat_ext = '0;
`endif

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      big_mant_d   = big_mant_q;
      small_ext_d  = small_ext_q;
      common_exp_d = common_exp_q;
      swapped_d    = swapped_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               big_mant_d   = diff_sign ? mant_b : mant_a;
               common_exp_d = diff_sign ? exp_b : exp_a;
               swapped_d    = diff_sign;
               count_d      = exp_diff;
               if (saturate) begin
                  small_ext_d = sat_ext;
                  state_d     = DONE;
               end else begin
                  small_ext_d = {other_mant, 3'b000};
                  state_d     = (exp_diff == '0) ? DONE : SHIFT;
               end
            end
         end
         SHIFT: begin
            small_ext_d = shifted;
            count_d     = count_q - 1'b1;
            if (count_q == EXP_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         count_q      <= '0;
         big_mant_q   <= '0;
         small_ext_q  <= '0;
         common_exp_q <= '0;
         swapped_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         big_mant_q   <= big_mant_d;
         small_ext_q  <= small_ext_d;
         common_exp_q <= common_exp_d;
         swapped_q    <= swapped_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign big_mant   = big_mant_q;
   assign small_ext  = small_ext_q;
   assign common_exp = common_exp_q;
   assign swapped    = swapped_q;
endmodule

// File: tb/tb_fpu_align_shifter.sv
// tb/tb_fpu_align_shifter.sv - directed bench for fpu_align_shifter with a latency/result model
// Literal expectations follow FPU_ALIGN_STICKY_EN when it is defined.
module tb_fpu_align_shifter;
   localparam int MW    = 24;
   localparam int EW    = 8;
   localparam int EXT_W = MW + 3;

`ifdef FPU_ALIGN_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [EW-1:0]    exp_diff = '0;
   logic             diff_sign = 1'b0;
   logic             diff_ovf = 1'b0;
   logic [EW-1:0]    exp_a = '0;
   logic [EW-1:0]    exp_b = '0;
   logic [MW-1:0]    mant_a = '0;
   logic [MW-1:0]    mant_b = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [MW-1:0]    big_mant;
   logic [EXT_W-1:0] small_ext;
   logic [EW-1:0]    common_exp;
   logic             swapped;

   int checks = 0;
   int errors = 0;

   fpu_align_shifter #(.MANT_W(MW), .EXP_W(EW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .exp_diff(exp_diff), .diff_sign(diff_sign), .diff_ovf(diff_ovf),
      .exp_a(exp_a), .exp_b(exp_b), .mant_a(mant_a), .mant_b(mant_b),
      .out_valid(out_valid), .out_ready(out_ready), .big_mant(big_mant),
      .small_ext(small_ext), .common_exp(common_exp), .swapped(swapped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_sat(input logic [EW-1:0] d, input logic ovf);
      return ovf || (int'(d) >= EXT_W);
   endfunction

   function automatic int model_lat(input logic [EW-1:0] d, input logic ovf);
      return (is_sat(d, ovf) || d == '0) ? 1 : int'(d) + 1;
   endfunction

   // Aligned value = full-precision right shift; S optionally ORs everything that fell off.
   function automatic logic [EXT_W-1:0] model_small(input logic [MW-1:0] m, input logic [EW-1:0] d,
                                                    input logic ovf);
      logic [EXT_W-1:0] ext;
      logic [EXT_W-1:0] lost_mask;
      ext = {m, 3'b000};
      if (is_sat(d, ovf)) return (STICKY && m != '0) ? EXT_W'(1) : EXT_W'(0);
      lost_mask = (EXT_W'(1) << d) - EXT_W'(1);
      if (STICKY) return (ext >> d) | (((ext & lost_mask) != '0) ? EXT_W'(1) : EXT_W'(0));
      return (ext >> d) & ~EXT_W'(1);
   endfunction

   logic             m_busy = 1'b0;
   int               m_wait = 0;
   logic [MW-1:0]    m_big = '0;
   logic [EXT_W-1:0] m_small = '0;
   logic [EW-1:0]    m_exp = '0;
   logic             m_swap = 1'b0;
   int               dut_xfers = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_wait <= 0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy  <= 1'b1;
            m_wait  <= model_lat(exp_diff, diff_ovf) - 1;
            m_big   <= diff_sign ? mant_b : mant_a;
            m_exp   <= diff_sign ? exp_b : exp_a;
            m_swap  <= diff_sign;
            m_small <= model_small(diff_sign ? mant_a : mant_b, exp_diff, diff_ovf);
         end
      end else if (m_wait != 0) begin
         m_wait <= m_wait - 1;
      end else if (out_ready) begin
         m_busy <= 1'b0;
      end
   end

   always @(posedge clk) begin
      if (!rst && out_valid && out_ready) dut_xfers <= dut_xfers + 1;
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("cmp in_ready", 32'(in_ready), 32'(!m_busy));
         chk("cmp out_valid", 32'(out_valid), 32'(m_busy && m_wait == 0));
         if (m_busy && m_wait == 0) begin
            chk("cmp big_mant", 32'(big_mant), 32'(m_big));
            chk("cmp small_ext", 32'(small_ext), 32'(m_small));
            chk("cmp common_exp", 32'(common_exp), 32'(m_exp));
            chk("cmp swapped", 32'(swapped), 32'(m_swap));
         end
      end
   end

   task automatic drive(input logic [EW-1:0] d, input logic sign, input logic ovf,
                        input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                        input logic [MW-1:0] ma, input logic [MW-1:0] mb);
      exp_diff = d; diff_sign = sign; diff_ovf = ovf;
      exp_a = ea; exp_b = eb; mant_a = ma; mant_b = mb;
      in_valid = 1'b1;
   endtask

   task automatic run_op(input string name, input logic [EW-1:0] d, input logic sign,
                         input logic ovf, input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                         input logic [MW-1:0] ma, input logic [MW-1:0] mb, input int exp_lat,
                         input logic [EXT_W-1:0] lit_small, input logic [MW-1:0] lit_big,
                         input logic [EW-1:0] lit_exp);
      int n;
      int lat;
      n = 0;
      while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
      drive(d, sign, ovf, ea, eb, ma, mb);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      chk({name, " latency"}, 32'(lat), 32'(exp_lat));
      chk({name, " small_ext"}, 32'(small_ext), 32'(lit_small));
      chk({name, " big_mant"}, 32'(big_mant), 32'(lit_big));
      chk({name, " common_exp"}, 32'(common_exp), 32'(lit_exp));
      chk({name, " swapped"}, 32'(swapped), 32'(sign));
      @(posedge clk); #1;
      chk({name, " in_ready after xfer"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [MW-1:0]    snap_big;
      logic [EXT_W-1:0] snap_small;
      logic [EW-1:0]    snap_exp;
      int               xs;
      int               lat;

      repeat (2) @(posedge clk);
      #1;
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset big_mant", 32'(big_mant), 32'd0);
      chk("reset small_ext", 32'(small_ext), 32'd0);
      chk("reset common_exp", 32'(common_exp), 32'd0);
      chk("reset swapped", 32'(swapped), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("diff0", 8'd0, 1'b0, 1'b0, 8'h7F, 8'h7F, 24'h800000, 24'hC00000, 1,
             27'h6000000, 24'h800000, 8'h7F);
      run_op("diff3", 8'd3, 1'b1, 1'b0, 8'h7F, 8'h82, 24'h800001, 24'hFFFFFF, 4,
             STICKY ? 27'h0800001 : 27'h0800000, 24'hFFFFFF, 8'h82);
      run_op("diff40", 8'd40, 1'b0, 1'b0, 8'hA7, 8'h7F, 24'hABCDEF, 24'h800000, 1,
             STICKY ? 27'h1 : 27'h0, 24'hABCDEF, 8'hA7);
      run_op("ovf", 8'd2, 1'b1, 1'b1, 8'h10, 8'h90, 24'h800000, 24'hC12345, 1,
             STICKY ? 27'h1 : 27'h0, 24'hC12345, 8'h90);
      run_op("diff12", 8'd12, 1'b0, 1'b0, 8'h8C, 8'h80, 24'hC00000, 24'hABCDEF, 13,
             STICKY ? 27'h00055E7 : 27'h00055E6, 24'hC00000, 8'h8C);
      run_op("zero shift", 8'd5, 1'b0, 1'b0, 8'h85, 8'h80, 24'h900000, 24'h000000, 6,
             27'h0, 24'h900000, 8'h85);
      run_op("zero sat", 8'd30, 1'b0, 1'b0, 8'h9E, 8'h80, 24'h900000, 24'h000000, 1,
             27'h0, 24'h900000, 8'h9E);
      run_op("diff27 sat", 8'd27, 1'b0, 1'b0, 8'h9B, 8'h80, 24'h123456, 24'h000001, 1,
             STICKY ? 27'h1 : 27'h0, 24'h123456, 8'h9B);
      run_op("b2b diff1", 8'd1, 1'b0, 1'b0, 8'h81, 8'h80, 24'h900000, 24'h800003, 2,
             27'h200000C, 24'h900000, 8'h81);
      run_op("b2b diff26", 8'd26, 1'b1, 1'b0, 8'h60, 8'h7A, 24'hFFFFFF, 24'h8ABCDE, 27,
             STICKY ? 27'h1 : 27'h0, 24'h8ABCDE, 8'h7A);

      out_ready = 1'b0;
      drive(8'd5, 1'b0, 1'b0, 8'h85, 8'h80, 24'hF00000, 24'h812345);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      chk("bp latency", 32'(lat), 32'd6);
      chk("bp small_ext", 32'(small_ext), STICKY ? 32'h2048D1 : 32'h2048D0);
      snap_big = big_mant; snap_small = small_ext; snap_exp = common_exp;
      xs = dut_xfers;
      for (int i = 0; i < 6; i++) begin
         if (i == 2) drive(8'd0, 1'b1, 1'b0, 8'h01, 8'h02, 24'h111111, 24'h222222);
         if (i == 3) in_valid = 1'b0;
         @(posedge clk); #1;
         chk("bp out_valid held", 32'(out_valid), 32'd1);
         chk("bp in_ready low", 32'(in_ready), 32'd0);
         chk("bp small stable", 32'(small_ext), 32'(snap_small));
         chk("bp big stable", 32'(big_mant), 32'(snap_big));
         chk("bp exp stable", 32'(common_exp), 32'(snap_exp));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp out_valid drop", 32'(out_valid), 32'd0);
      chk("bp in_ready back", 32'(in_ready), 32'd1);
      chk("bp single xfer", 32'(dut_xfers - xs), 32'd1);

      drive(8'd20, 1'b0, 1'b0, 8'h94, 8'h80, 24'hFFFFFF, 24'hABCDEF);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst small_ext", 32'(small_ext), 32'd0);
      chk("rst big_mant", 32'(big_mant), 32'd0);
      chk("rst common_exp", 32'(common_exp), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      run_op("post rst", 8'd0, 1'b1, 1'b0, 8'h40, 8'h40, 24'hA00000, 24'hB00000, 1,
             27'h5000000, 24'hB00000, 8'h40);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
